// File: rtl/round_score_gen_if.sv
// round_score_gen_if
//   Report channel between the round generator and the score tracker.
//   master : round generator side (drives score/playerID/isGuest/score_req)
//   slave  : score tracker side (drives trackerValid)
//   Signals:
//     score        [6:0]  final (or running) round score
//     playerID     [2:0]  player identity latched at round start
//     isGuest             guest flag latched at round start
//     score_req           one-cycle request, payload already stable
//     trackerValid        tracker acknowledge
interface round_score_gen_if;
    logic [6:0] score;
    logic [2:0] playerID;
    logic       isGuest;
    logic       score_req;
    logic       trackerValid;

    modport master (
        output score,
        output playerID,
        output isGuest,
        output score_req,
        input  trackerValid
    );

    modport slave (
        input  score,
        input  playerID,
        input  isGuest,
        input  score_req,
        output trackerValid
    );
endinterface

// File: rtl/round_score_gen.sv
// round_score_gen
//   Runs one timed game round, counts hit pulses into a saturating 7-bit
//   score, reports the result to the score tracker with a one-cycle
//   score_req and waits (bounded) for the tracker's acknowledge.
//   Optional build macro: ROUND_SCORE_MISS_PENALTY_EN
//     defined   : miss pulses in PLAY decrement the score (floor 0);
//                 hit and miss together leave the score unchanged
//     undefined : miss is ignored
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     start            one-cycle pulse, begins a round from IDLE
//     hit, miss        scoring event pulses
//     playerIDIn       player identity, latched on accepted start
//     isGuestIn        guest flag, latched on accepted start
//     trk              report channel (master side)
//     busy             high in every state except IDLE
//     secsLeft         remaining round seconds
//     ackTimeout       sticky: tracker never answered last report
module round_score_gen #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned ROUND_SECS    = 15,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     hit,
    input  logic                     miss,
    input  logic [2:0]               playerIDIn,
    input  logic                     isGuestIn,
    round_score_gen_if.master        trk,
    output logic                     busy,
    output logic [5:0]               secsLeft,
    output logic                     ackTimeout
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        REPORT,
        WAIT_ACK
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     score_q, score_d;
    logic [2:0]     player_id_q, player_id_d;
    logic           is_guest_q, is_guest_d;
    logic [5:0]     secs_q, secs_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [7:0]     ack_cnt_q, ack_cnt_d;
    logic           ack_to_q, ack_to_d;

    logic [6:0]     score_step;
    logic [8:0]     ack_cnt_inc;

    // Score update applied on every PLAY cycle.
`ifdef ROUND_SCORE_MISS_PENALTY_EN
    always_comb begin
        score_step = score_q;
        if (hit && !miss) begin
            if (score_q != 7'd127) score_step = score_q + 7'd1;
        end else if (miss && !hit) begin
            if (score_q != 7'd0) score_step = score_q - 7'd1;
        end
    end
`else
    logic miss_unused;
    assign miss_unused = miss;

    always_comb begin
        score_step = score_q;
        if (hit && (score_q != 7'd127)) score_step = score_q + 7'd1;
    end
`endif

    // Widened so ACK_TIMEOUT=255 cannot wrap the comparison.
    assign ack_cnt_inc = {1'b0, ack_cnt_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        player_id_d = player_id_q;
        is_guest_d  = is_guest_q;
        secs_d      = secs_q;
        presc_d     = presc_q;
        ack_cnt_d   = ack_cnt_q;
        ack_to_d    = ack_to_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PLAY;
                    score_d     = '0;
                    secs_d      = 6'(ROUND_SECS);
                    presc_d     = '0;
                    player_id_d = playerIDIn;
                    is_guest_d  = isGuestIn;
                    ack_to_d    = 1'b0;
                end
            end
            PLAY: begin
                score_d = score_step;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    secs_d  = secs_q - 6'd1;
                    if (secs_q == 6'd1) state_d = REPORT;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            REPORT: begin
                state_d   = WAIT_ACK;
                ack_cnt_d = '0;
            end
            WAIT_ACK: begin
                // An acknowledge in the timeout cycle still counts as answered.
                if (trk.trackerValid) begin
                    state_d = IDLE;
                end else if (ack_cnt_inc == 9'(ACK_TIMEOUT)) begin
                    state_d  = IDLE;
                    ack_to_d = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_inc[7:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            score_q     <= '0;
            player_id_q <= '0;
            is_guest_q  <= 1'b0;
            secs_q      <= '0;
            presc_q     <= '0;
            ack_cnt_q   <= '0;
            ack_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            player_id_q <= player_id_d;
            is_guest_q  <= is_guest_d;
            secs_q      <= secs_d;
            presc_q     <= presc_d;
            ack_cnt_q   <= ack_cnt_d;
            ack_to_q    <= ack_to_d;
        end
    end

    assign trk.score     = score_q;
    assign trk.playerID  = player_id_q;
    assign trk.isGuest   = is_guest_q;
    assign trk.score_req = (state_q == REPORT);
    assign busy          = (state_q != IDLE);
    assign secsLeft      = secs_q;
    assign ackTimeout    = ack_to_q;

endmodule

// File: tb/tb_round_score_gen.sv
// tb_round_score_gen
//   dut_a: TICKS_PER_SEC=4,   ROUND_SECS=3, ACK_TIMEOUT=5
//   dut_b: TICKS_PER_SEC=100, ROUND_SECS=2, ACK_TIMEOUT=5
//   Expected reports {score, playerID, isGuest} are queued when a round is
//   started and popped when that DUT raises score_req.
module tb_round_score_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, hit, miss, guest_in;
    logic [2:0] pid_in;
    logic       busy_a, busy_b, ackto_a, ackto_b;
    logic [5:0] secs_a, secs_b;

    round_score_gen_if ifa ();
    round_score_gen_if ifb ();

    round_score_gen #(.TICKS_PER_SEC(4), .ROUND_SECS(3), .ACK_TIMEOUT(5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .hit(hit), .miss(miss),
        .playerIDIn(pid_in), .isGuestIn(guest_in), .trk(ifa.master),
        .busy(busy_a), .secsLeft(secs_a), .ackTimeout(ackto_a)
    );

    round_score_gen #(.TICKS_PER_SEC(100), .ROUND_SECS(2), .ACK_TIMEOUT(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hit(hit), .miss(miss),
        .playerIDIn(pid_in), .isGuestIn(guest_in), .trk(ifb.master),
        .busy(busy_b), .secsLeft(secs_b), .ackTimeout(ackto_b)
    );

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q_a[$];
    logic [10:0] exp_q_b[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; hit = 1'b0; miss = 1'b0;
        pid_in = 3'd0; guest_in = 1'b0;
        ifa.trackerValid = 1'b0; ifb.trackerValid = 1'b0;
        tick(); tick();
        checks++;
        if ({ifa.score, ifa.playerID, ifa.isGuest, ifa.score_req, busy_a, secs_a, ackto_a} !== 20'h0) begin
            errors++;
            $display("FAIL reset_a: got %h expected 0", {ifa.score, ifa.playerID, ifa.isGuest, ifa.score_req, busy_a, secs_a, ackto_a});
        end
        checks++;
        if ({ifb.score, ifb.playerID, ifb.isGuest, ifb.score_req, busy_b, secs_b, ackto_b} !== 20'h0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0", {ifb.score, ifb.playerID, ifb.isGuest, ifb.score_req, busy_b, secs_b, ackto_b});
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_hit();
        hit = 1'b1;
        tick(); tick(); tick();
        hit = 1'b0;
        tick();
        checks++;
        if (ifa.score !== 7'd0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_hit: got score=%0d busy=%0b expected score=0 busy=0", ifa.score, busy_a);
        end
    endtask

    task automatic test_basic_round();
        int k;
        logic [10:0] e;
        pid_in = 3'd2; guest_in = 1'b0;
        exp_q_a.push_back({7'd2, 3'd2, 1'b0});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        pid_in = 3'd5;
        checks++;
        if (busy_a !== 1'b1 || secs_a !== 6'd3) begin
            errors++;
            $display("FAIL start_latency: got busy=%0b secs=%0d expected busy=1 secs=3", busy_a, secs_a);
        end
        k = 0;
        while (ifa.score_req !== 1'b1 && k < 40) begin
            hit = (k == 2 || k == 5);
            tick();
            k++;
            if (k % 4 == 0 && k <= 12) begin
                checks++;
                if (secs_a !== 6'(3 - k / 4)) begin
                    errors++;
                    $display("FAIL secs_step k=%0d: got %0d expected %0d", k, secs_a, 3 - k / 4);
                end
            end
        end
        hit = 1'b0;
        checks++;
        if (k != 12) begin
            errors++;
            $display("FAIL play_len: got %0d expected 12", k);
        end
        checks++;
        if (ifa.score_req !== 1'b1 || exp_q_a.size() == 0) begin
            errors++;
            $display("FAIL report_basic: got score_req=%0b expected 1", ifa.score_req);
        end else begin
            e = exp_q_a.pop_front();
            if ({ifa.score, ifa.playerID, ifa.isGuest} !== e) begin
                errors++;
                $display("FAIL report_basic: got %h expected %h", {ifa.score, ifa.playerID, ifa.isGuest}, e);
            end
        end
        tick();
        checks++;
        if (ifa.score_req !== 1'b0) begin
            errors++;
            $display("FAIL req_one_cycle: got %0b expected 0", ifa.score_req);
        end
        tick(); tick();
        ifa.trackerValid = 1'b1;
        tick();
        ifa.trackerValid = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || ackto_a !== 1'b0) begin
            errors++;
            $display("FAIL ack_accept: got busy=%0b ackTimeout=%0b expected 0 0", busy_a, ackto_a);
        end
        tick(); tick(); tick();
        checks++;
        if (ifa.score !== 7'd2 || ifa.playerID !== 3'd2) begin
            errors++;
            $display("FAIL score_hold: got score=%0d pid=%0d expected 2 2", ifa.score, ifa.playerID);
        end
    endtask

    task automatic test_final_hit_timeout();
        int k;
        int n;
        logic [10:0] e;
        pid_in = 3'd4; guest_in = 1'b1;
        exp_q_a.push_back({7'd1, 3'd4, 1'b1});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (ifa.score_req !== 1'b1 && k < 40) begin
            hit = (k == 11);
            tick();
            k++;
        end
        hit = 1'b0;
        checks++;
        if (ifa.score_req !== 1'b1 || exp_q_a.size() == 0) begin
            errors++;
            $display("FAIL report_final_hit: got score_req=%0b after %0d cycles expected 1", ifa.score_req, k);
        end else begin
            e = exp_q_a.pop_front();
            if ({ifa.score, ifa.playerID, ifa.isGuest} !== e) begin
                errors++;
                $display("FAIL report_final_hit: got %h expected %h", {ifa.score, ifa.playerID, ifa.isGuest}, e);
            end
        end
        tick();
        n = 0;
        while (busy_a === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 5 || ackto_a !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: got wait=%0d ackTimeout=%0b expected 5 1", n, ackto_a);
        end
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if (ackto_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL ack_clear: got ackTimeout=%0b busy=%0b expected 0 1", ackto_a, busy_a);
        end
    endtask

    // Continues inside the round started at the end of the previous task.
    task automatic test_midround_reset();
        int seen;
        for (int i = 0; i < 5; i++) begin
            hit = 1'b1;
            tick();
        end
        hit = 1'b0;
        checks++;
        if (ifa.score !== 7'd5 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_score: got score=%0d busy=%0b expected 5 1", ifa.score, busy_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || ifa.score !== 7'd0 || ifa.playerID !== 3'd0 || secs_a !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%0b score=%0d pid=%0d secs=%0d expected all 0", busy_a, ifa.score, ifa.playerID, secs_a);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifa.score_req === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_req_after_reset: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_dropped_start();
        int k;
        logic [10:0] e;
        pid_in = 3'd3; guest_in = 1'b1;
        exp_q_a.push_back({7'd0, 3'd3, 1'b1});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (ifa.score_req !== 1'b1 && k < 40) begin
            start_a = (k == 3 || k == 10);
            if (k == 3) pid_in = 3'd7;
            tick();
            k++;
        end
        start_a = 1'b0;
        checks++;
        if (k != 12) begin
            errors++;
            $display("FAIL dropped_start_len: got %0d expected 12", k);
        end
        checks++;
        if (ifa.score_req !== 1'b1 || exp_q_a.size() == 0) begin
            errors++;
            $display("FAIL report_dropped: got score_req=%0b expected 1", ifa.score_req);
        end else begin
            e = exp_q_a.pop_front();
            if ({ifa.score, ifa.playerID, ifa.isGuest} !== e) begin
                errors++;
                $display("FAIL report_dropped: got %h expected %h", {ifa.score, ifa.playerID, ifa.isGuest}, e);
            end
        end
        tick();
        ifa.trackerValid = 1'b1;
        tick();
        ifa.trackerValid = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || ackto_a !== 1'b0) begin
            errors++;
            $display("FAIL dropped_ack: got busy=%0b ackTimeout=%0b expected 0 0", busy_a, ackto_a);
        end
    endtask

    task automatic test_saturation();
        int k;
        int s;
        logic [10:0] e;
        s = 0;
        for (int i = 0; i < 200; i++) if (s < 127) s++;
        pid_in = 3'd6; guest_in = 1'b0;
        exp_q_b.push_back({7'(s), 3'd6, 1'b0});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        k = 0;
        hit = 1'b1;
        while (ifb.score_req !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        hit = 1'b0;
        checks++;
        if (k != 200) begin
            errors++;
            $display("FAIL sat_play_len: got %0d expected 200", k);
        end
        checks++;
        if (ifb.score_req !== 1'b1 || exp_q_b.size() == 0) begin
            errors++;
            $display("FAIL report_sat: got score_req=%0b expected 1", ifb.score_req);
        end else begin
            e = exp_q_b.pop_front();
            if ({ifb.score, ifb.playerID, ifb.isGuest} !== e) begin
                errors++;
                $display("FAIL report_sat: got %h expected %h", {ifb.score, ifb.playerID, ifb.isGuest}, e);
            end
        end
        tick();
        ifb.trackerValid = 1'b1;
        tick();
        ifb.trackerValid = 1'b0;
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL sat_ack: got busy=%0b expected 0", busy_b);
        end
    endtask

    task automatic test_miss();
        int k;
        logic [10:0] e;
        logic [6:0] after_hits;
        logic [6:0] after_miss;
        logic [6:0] after_both;
`ifdef ROUND_SCORE_MISS_PENALTY_EN
        after_hits = 7'd3; after_miss = 7'd0; after_both = 7'd0;
`else
        after_hits = 7'd3; after_miss = 7'd3; after_both = 7'd4;
`endif
        pid_in = 3'd1; guest_in = 1'b0;
        exp_q_a.push_back({after_both, 3'd1, 1'b0});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (ifa.score_req !== 1'b1 && k < 40) begin
            hit  = (k < 3) || (k == 8);
            miss = (k >= 3 && k <= 8);
            tick();
            k++;
            if (k == 3 || k == 8 || k == 9) begin
                checks++;
                if (ifa.score !== ((k == 3) ? after_hits : (k == 8) ? after_miss : after_both)) begin
                    errors++;
                    $display("FAIL miss_step k=%0d: got %0d expected %0d", k, ifa.score,
                             (k == 3) ? after_hits : (k == 8) ? after_miss : after_both);
                end
            end
        end
        hit = 1'b0; miss = 1'b0;
        checks++;
        if (ifa.score_req !== 1'b1 || exp_q_a.size() == 0) begin
            errors++;
            $display("FAIL report_miss: got score_req=%0b expected 1", ifa.score_req);
        end else begin
            e = exp_q_a.pop_front();
            if ({ifa.score, ifa.playerID, ifa.isGuest} !== e) begin
                errors++;
                $display("FAIL report_miss: got %h expected %h", {ifa.score, ifa.playerID, ifa.isGuest}, e);
            end
        end
        tick();
        ifa.trackerValid = 1'b1;
        tick();
        ifa.trackerValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_hit();
        test_basic_round();
        test_final_hit_timeout();
        test_midround_reset();
        test_dropped_start();
        test_saturation();
        test_miss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_score_gen.md
Name: round_score_gen

Overview:
- Upstream stage of the score tracker: runs one timed game round and counts hit events into a 7-bit score.
- At round end it presents score, playerID and isGuest, stable, then issues a one-cycle score_req pulse.
- Waits for the tracker's valid before accepting the next round.
- One clock domain; sits between the player input debouncers and the score tracker.

Parameters:
- TICKS_PER_SEC, 50000000: clk cycles per round-timer second.
- ROUND_SECS, 15: round length in seconds (1..63).
- ACK_TIMEOUT, 255: clk cycles to wait for trackerValid before giving up (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse; begins a round when in IDLE
- hit  input  1  one-cycle pulse per scoring event
- miss  input  1  one-cycle pulse per missed event (used only with the optional feature)
- playerIDIn  input  3  player identity, sampled on accepted start
- isGuestIn  input  1  guest flag, sampled on accepted start
- trackerValid  input  1  valid output from the score tracker
- score  output  7  current or final round score
- playerID  output  3  latched player identity
- isGuest  output  1  latched guest flag
- score_req  output  1  one-cycle request to the tracker
- busy  output  1  high in every state except IDLE
- secsLeft  output  6  remaining round seconds
- ackTimeout  output  1  sticky flag: tracker did not answer; cleared on next accepted start

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, all counters 0, all outputs 0. Reset has priority over every other input in every state, including mid-round and during REPORT/WAIT_ACK.
- IDLE:
  - start=1 → PLAY next cycle.
  - Load: score=0, secsLeft=ROUND_SECS, prescaler=0; latch playerIDIn and isGuestIn; clear ackTimeout.
  - hit and miss are ignored.
- PLAY:
  - Prescaler counts 0..TICKS_PER_SEC-1. On wrap, secsLeft decrements.
  - hit=1 → score+1, saturating at 127 (hit at 127 leaves 127).
  - start is ignored.
  - Round end: when secsLeft is 1 and the prescaler wraps, secsLeft becomes 0 and state goes to REPORT.
  - A hit in that same final cycle is counted.
- REPORT (exactly one cycle): score_req=1. score, playerID and isGuest are already stable and stay stable until the next accepted start. → WAIT_ACK.
- WAIT_ACK:
  - The cycle counter starts at 0 on entry.
  - trackerValid=1 → IDLE.
  - Counter reaches ACK_TIMEOUT without trackerValid → ackTimeout=1, IDLE.
  - If both happen in the same cycle, trackerValid wins and ackTimeout stays 0.
- Input rules:
  - hit and miss outside PLAY: no effect.
  - start in PLAY, REPORT or WAIT_ACK: dropped, never queued.
- Latency:
  - Accepted start → busy=1 on the next cycle.
  - Round length: exactly ROUND_SECS*TICKS_PER_SEC cycles in PLAY.
  - score_req: the cycle after PLAY ends.
- Held outputs: score keeps its final value in IDLE until the next accepted start.

Optional Feature:
- Macro: ROUND_SCORE_MISS_PENALTY_EN.
- Defined: in PLAY, miss=1 decrements score, saturating at 0.
  - hit and miss in the same cycle: score unchanged.
- Not defined: the miss port is present but ignored; score only increments.

Test Plan:
- Reset and idle:
  - Hold rst=1 for 2 cycles → all outputs 0, busy=0.
  - Then hit pulses while in IDLE → score stays 0.
- Basic round (TICKS_PER_SEC=4, ROUND_SECS=3):
  - Stimulus: start with playerIDIn=2, isGuestIn=0; 2 hits during PLAY; trackerValid pulsed 3 cycles after score_req.
  - Expected: exactly 12 PLAY cycles; secsLeft steps 3,2,1,0; score_req high for one cycle with score=2, playerID=2.
  - Expected: busy=0 after trackerValid; score holds 2.
- Saturation and final-cycle hit:
  - Stimulus: hit every cycle with TICKS_PER_SEC=100, ROUND_SECS=2.
  - Expected: score=127 at score_req; a hit in the final PLAY cycle is counted.
- Ack timeout (ACK_TIMEOUT=5):
  - Stimulus: trackerValid held 0 → IDLE 5 cycles after entering WAIT_ACK, ackTimeout=1.
  - Stimulus: next start → ackTimeout=0.
- Mid-round reset and dropped start:
  - rst=1 during PLAY with score=5 → next cycle IDLE, score=0, no score_req.
  - start during PLAY → ignored, round length unchanged.
- Penalty (macro defined):
  - Stimulus: 3 hits, then 5 misses, then hit and miss together.
  - Expected: score 3, then 0 (floored), then unchanged at 0; reported score=0.
